// File: rtl/brew_sequencer.sv
// Drink-cycle sequencer: IDLE -> WATER -> HEAT -> BREW -> MILK -> DONE with recipe table and prescaled tick.
// All outputs registered; one-cycle response to button pulses, countdown advances on each prescaler tick.
module brew_sequencer #(
    parameter int CLK_DIV  = 50000,
    parameter int N_DRINKS = 4,
    parameter int TIME_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btnl,
    input  logic                        btnr,
    input  logic                        btnd,
    input  logic                        btnp,
    input  logic                        btnu,
    input  logic [3:0]                  speed,
    output logic [$clog2(N_DRINKS)-1:0] drink_sel,
    output logic [2:0]                  stage,
    output logic [TIME_W-1:0]           remaining,
    output logic                        busy,
    output logic                        paused,
    output logic [7:2]                  led
);

    localparam int SEL_W = $clog2(N_DRINKS);
    localparam int PW    = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WATER = 3'd1,
        ST_HEAT  = 3'd2,
        ST_BREW  = 3'd3,
        ST_MILK  = 3'd4,
        ST_DONE  = 3'd5
    } stage_t;

    function automatic logic [TIME_W-1:0] stage_dur(input stage_t s, input logic [SEL_W-1:0] d);
        int unsigned v;
        v = 0;
        case (s)
            ST_WATER: v = 32'd4 + 32'd2 * 32'(d);
            ST_HEAT:  v = 32'd6;
            ST_BREW:  v = 32'd8 + 32'd4 * 32'(d);
            ST_MILK:  v = 32'd3 * 32'(d);
            default:  v = 32'd0;
        endcase
        return TIME_W'(v);
    endfunction

    // First later stage with a non-zero duration; DONE if none remain.
    function automatic stage_t next_stage(input stage_t s, input logic [SEL_W-1:0] d);
        stage_t r;
        r = ST_DONE;
        for (int i = 4; i >= 1; i--) begin
            if (i > int'(s) && stage_dur(stage_t'(3'(i)), d) != '0) begin
                r = stage_t'(3'(i));
            end
        end
        return r;
    endfunction

    stage_t             stage_q, stage_d;
    logic [SEL_W-1:0]   drink_sel_q, drink_sel_d;
    logic [TIME_W-1:0]  remaining_q, remaining_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               paused_q, paused_d;
    logic               busy_q, busy_d;
    logic [7:2]         led_q, led_d;

    logic               stage_busy;
    logic               count_en;
    logic               tick;
    logic [4:0]         step;
    stage_t             nxt_stage;
    logic [TIME_W-1:0]  nxt_dur;

    assign stage_busy = (stage_q inside {ST_WATER, ST_HEAT, ST_BREW, ST_MILK});
    assign count_en   = stage_busy && !paused_q;
    assign tick       = count_en && (presc_q == PW'(CLK_DIV - 1));
    assign step       = (speed == 4'd0) ? 5'd1 : {1'b0, speed};
    assign nxt_stage  = next_stage(stage_q, drink_sel_q);
    assign nxt_dur    = stage_dur(nxt_stage, drink_sel_q);

    always_comb begin
        stage_d     = stage_q;
        drink_sel_d = drink_sel_q;
        remaining_d = remaining_q;
        paused_d    = paused_q;
        presc_d     = presc_q;
        if (count_en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (stage_busy) begin
            if (btnu) begin
                stage_d     = ST_IDLE;
                remaining_d = '0;
                paused_d    = 1'b0;
                presc_d     = '0;
            end else begin
                if (tick) begin
                    if (32'(remaining_q) > 32'(step)) begin
                        remaining_d = remaining_q - TIME_W'(step);
                    end else begin
                        stage_d     = nxt_stage;
                        remaining_d = nxt_dur;
                    end
                end
                // Tick lands first; a pause that coincides with entering DONE is dropped.
                if (btnp && stage_d != ST_DONE) begin
                    paused_d = !paused_q;
                end
            end
        end else if (stage_q == ST_IDLE) begin
            if (btnd) begin
                stage_d     = nxt_stage;
                remaining_d = nxt_dur;
                presc_d     = '0;
            end else if (btnr && !btnl) begin
                drink_sel_d = (32'(drink_sel_q) == N_DRINKS - 1) ? '0 : drink_sel_q + SEL_W'(1);
            end else if (btnl && !btnr) begin
                drink_sel_d = (drink_sel_q == '0) ? SEL_W'(N_DRINKS - 1) : drink_sel_q - SEL_W'(1);
            end
        end else if (btnd || btnu) begin
            stage_d     = ST_IDLE;
            remaining_d = '0;
            paused_d    = 1'b0;
        end

        busy_d = (stage_d inside {ST_WATER, ST_HEAT, ST_BREW, ST_MILK});
        led_d  = '0;
        case (stage_d)
            ST_WATER: led_d[2] = 1'b1;
            ST_HEAT:  led_d[3] = 1'b1;
            ST_BREW:  led_d[4] = 1'b1;
            ST_MILK:  led_d[5] = 1'b1;
            ST_DONE:  led_d[7] = 1'b1;
            default:  led_d    = '0;
        endcase
        led_d[6] = paused_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q     <= ST_IDLE;
            drink_sel_q <= '0;
            remaining_q <= '0;
            presc_q     <= '0;
            paused_q    <= 1'b0;
            busy_q      <= 1'b0;
            led_q       <= '0;
        end else begin
            stage_q     <= stage_d;
            drink_sel_q <= drink_sel_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            paused_q    <= paused_d;
            busy_q      <= busy_d;
            led_q       <= led_d;
        end
    end

    assign drink_sel = drink_sel_q;
    assign stage     = stage_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;
    assign paused    = paused_q;
    assign led       = led_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer with CLK_DIV=4, N_DRINKS=4, TIME_W=8.
module tb_brew_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btnl, btnr, btnd, btnp, btnu;
    logic [3:0] speed;
    logic [1:0] drink_sel;
    logic [2:0] stage;
    logic [7:0] remaining;
    logic       busy, paused;
    logic [7:2] led;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    brew_sequencer #(.CLK_DIV(4), .N_DRINKS(4), .TIME_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .btnl(btnl), .btnr(btnr), .btnd(btnd), .btnp(btnp), .btnu(btnu),
        .speed(speed),
        .drink_sel(drink_sel), .stage(stage), .remaining(remaining),
        .busy(busy), .paused(paused), .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic l, input logic r, input logic d, input logic p, input logic u);
        btnl = l; btnr = r; btnd = d; btnp = p; btnu = u;
        cycle();
        btnl = 0; btnr = 0; btnd = 0; btnp = 0; btnu = 0;
    endtask

    task automatic wait_stage(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (stage !== s && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (stage !== s) begin
            errors++;
            $display("FAIL wait_stage: stage=%0d required=%0d within %0d cycles", stage, s, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; speed = 4'd1;
        btnl = 0; btnr = 0; btnd = 0; btnp = 0; btnu = 0;
        cycle(); cycle();
        checks++;
        if ({stage, drink_sel, remaining, busy, paused, led} !== '0) begin
            errors++;
            $display("FAIL reset_hold: stage=%0d sel=%0d rem=%0d busy=%b paused=%b led=%b, required all 0",
                     stage, drink_sel, remaining, busy, paused, led);
        end
        rst_n = 1;
        cycle(); cycle();
        checks++;
        if (stage !== 3'd0 || drink_sel !== 2'd0 || led !== 6'b0) begin
            errors++;
            $display("FAIL reset_release: stage=%0d sel=%0d led=%b, required 0/0/0", stage, drink_sel, led);
        end
    endtask

    task automatic test_full_cycle();
        int t0;
        press(0, 0, 1, 0, 0);
        t0 = cyc;
        checks++;
        if (stage !== 3'd1 || remaining !== 8'd4 || busy !== 1'b1 || led !== 6'b000001) begin
            errors++;
            $display("FAIL start: stage=%0d rem=%0d busy=%b led=%b, required 1/4/1/000001", stage, remaining, busy, led);
        end
        wait_stage(3'd2, 100);
        checks++;
        if (cyc - t0 !== 16) begin errors++; $display("FAIL water_len: %0d cycles, required 16", cyc - t0); end
        wait_stage(3'd3, 100);
        checks++;
        if (cyc - t0 !== 40) begin errors++; $display("FAIL heat_end: %0d cycles, required 40", cyc - t0); end
        wait_stage(3'd5, 100);
        checks++;
        if (cyc - t0 !== 72) begin errors++; $display("FAIL done_time: %0d cycles, required 72", cyc - t0); end
        checks++;
        if (led !== 6'b100000 || busy !== 1'b0 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL done_out: led=%b busy=%b rem=%0d, required 100000/0/0", led, busy, remaining);
        end
        press(0, 0, 0, 1, 0);
        press(0, 1, 0, 0, 0);
        checks++;
        if (stage !== 3'd5 || paused !== 1'b0 || drink_sel !== 2'd0) begin
            errors++;
            $display("FAIL done_ignore: stage=%0d paused=%b sel=%0d, required 5/0/0", stage, paused, drink_sel);
        end
        press(0, 0, 1, 0, 0);
        checks++;
        if (stage !== 3'd0 || led !== 6'b0) begin
            errors++;
            $display("FAIL done_ack: stage=%0d led=%b, required 0/000000", stage, led);
        end
    endtask

    task automatic test_speed();
        int exp_rem [8] = '{6, 2, 6, 2, 12, 8, 4, 3};
        int got [$];
        logic [10:0] prev;
        int t0, n;
        speed = 4'd4;
        press(0, 1, 0, 0, 0);
        checks++;
        if (drink_sel !== 2'd1) begin errors++; $display("FAIL sel_next: sel=%0d, required 1", drink_sel); end
        press(0, 0, 1, 0, 0);
        t0 = cyc;
        got.push_back(int'(remaining));
        prev = {stage, remaining};
        n = 0;
        while (stage !== 3'd5 && n < 200) begin
            cycle();
            n++;
            if (stage !== 3'd5 && {stage, remaining} !== prev) got.push_back(int'(remaining));
            prev = {stage, remaining};
        end
        checks++;
        if (cyc - t0 !== 32) begin errors++; $display("FAIL speed_done: %0d cycles, required 32", cyc - t0); end
        checks++;
        if (got.size() !== 8) begin
            errors++;
            $display("FAIL speed_trace_len: %0d values, required 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== exp_rem[i]) begin
                    errors++;
                    $display("FAIL speed_trace[%0d]: rem=%0d, required %0d", i, got[i], exp_rem[i]);
                end
            end
        end
        press(0, 0, 0, 0, 1);
        checks++;
        if (stage !== 3'd0 || drink_sel !== 2'd1) begin
            errors++;
            $display("FAIL done_cancel: stage=%0d sel=%0d, required 0/1", stage, drink_sel);
        end
        speed = 4'd1;
    endtask

    task automatic test_select_wrap();
        test_reset();
        press(1, 0, 0, 0, 0);
        checks++;
        if (drink_sel !== 2'd3) begin errors++; $display("FAIL sel_wrap: sel=%0d, required 3", drink_sel); end
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        checks++;
        if (drink_sel !== 2'd1) begin errors++; $display("FAIL sel_up2: sel=%0d, required 1", drink_sel); end
        press(1, 1, 0, 0, 0);
        checks++;
        if (drink_sel !== 2'd1) begin errors++; $display("FAIL sel_both: sel=%0d, required 1", drink_sel); end
        press(0, 1, 1, 0, 0);
        checks++;
        if (stage !== 3'd1 || drink_sel !== 2'd1 || remaining !== 8'd6) begin
            errors++;
            $display("FAIL start_sel: stage=%0d sel=%0d rem=%0d, required 1/1/6", stage, drink_sel, remaining);
        end
    endtask

    task automatic test_pause();
        int tb, tp, tr;
        logic [7:0] r;
        test_reset();
        press(0, 0, 1, 0, 0);
        wait_stage(3'd3, 200);
        tb = cyc;
        repeat (10) cycle();
        press(0, 0, 0, 1, 0);
        tp = cyc;
        r = remaining;
        checks++;
        if (paused !== 1'b1 || led[6] !== 1'b1 || busy !== 1'b1 || r !== 8'd6) begin
            errors++;
            $display("FAIL pause_set: paused=%b led6=%b busy=%b rem=%0d, required 1/1/1/6", paused, led[6], busy, r);
        end
        repeat (100) cycle();
        checks++;
        if (remaining !== r || stage !== 3'd3) begin
            errors++;
            $display("FAIL pause_hold: rem=%0d stage=%0d, required %0d/3", remaining, stage, r);
        end
        press(0, 0, 0, 1, 0);
        tr = cyc;
        checks++;
        if (paused !== 1'b0 || led[6] !== 1'b0) begin
            errors++;
            $display("FAIL pause_clear: paused=%b led6=%b, required 0/0", paused, led[6]);
        end
        wait_stage(3'd5, 300);
        checks++;
        if (cyc - tb !== 32 + (tr - tp)) begin
            errors++;
            $display("FAIL pause_extend: brew %0d cycles, required %0d", cyc - tb, 32 + (tr - tp));
        end
        press(0, 0, 1, 0, 0);
    endtask

    task automatic test_cancel();
        press(0, 1, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        wait_stage(3'd2, 200);
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 1, 1);
        checks++;
        if (stage !== 3'd0 || paused !== 1'b0 || remaining !== 8'd0 || drink_sel !== 2'd1 ||
            busy !== 1'b0 || led !== 6'b0) begin
            errors++;
            $display("FAIL cancel: stage=%0d paused=%b rem=%0d sel=%0d busy=%b led=%b, required 0/0/0/1/0/000000",
                     stage, paused, remaining, drink_sel, busy, led);
        end
        press(0, 0, 0, 0, 1);
        checks++;
        if (stage !== 3'd0 || drink_sel !== 2'd1) begin
            errors++;
            $display("FAIL cancel_idle: stage=%0d sel=%0d, required 0/1", stage, drink_sel);
        end
    endtask

    task automatic test_midreset();
        int t0;
        speed = 4'd0;
        press(0, 0, 1, 0, 0);
        t0 = cyc;
        wait_stage(3'd4, 300);
        checks++;
        if (cyc - t0 !== 96 || remaining !== 8'd3) begin
            errors++;
            $display("FAIL speed0_milk: %0d cycles rem=%0d, required 96/3", cyc - t0, remaining);
        end
        cycle(); cycle();
        #3 rst_n = 0;
        #1;
        checks++;
        if ({stage, drink_sel, remaining, busy, paused, led} !== '0) begin
            errors++;
            $display("FAIL async_reset: stage=%0d sel=%0d rem=%0d busy=%b paused=%b led=%b, required all 0",
                     stage, drink_sel, remaining, busy, paused, led);
        end
        #2 rst_n = 1;
        repeat (6) cycle();
        checks++;
        if (stage !== 3'd0 || drink_sel !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: stage=%0d sel=%0d busy=%b, required 0/0/0", stage, drink_sel, busy);
        end
        speed = 4'd1;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_speed();
        test_select_wrap();
        test_pause();
        test_cancel();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
